// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: register selects, Status/Cause field positions,
// exception codes and the acknowledge FSM state type.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int unsigned ST_IE     = 0;
    localparam int unsigned ST_EXL    = 1;
    localparam int unsigned ST_IM     = 8;
    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned CA_ACKTO  = 7;
    localparam int unsigned CA_IP     = 8;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    typedef enum logic {IDLE, ACK} ack_state_t;

    // A single interrupt line still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_irq_arbiter.sv
// Lowest-index-wins priority encoder over the masked pending interrupts.
module irq_arbiter
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0]              req,
    output logic                            valid,
    output logic [idx_width(NUM_IRQ)-1:0]   idx
);

    localparam int unsigned IW = idx_width(NUM_IRQ);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 Status/Cause/EPC with exception/interrupt arbitration, PC redirect,
// mfc0/mtc0/eret service and a per-line interrupt acknowledge handshake.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_IRQ   = 4,
    parameter logic [31:0] VEC_EXC   = 32'h0000_001c,
    parameter logic [31:0] VEC_IRQ   = 32'h0000_0040,
    parameter int unsigned VEC_SHIFT = 3,
    parameter int unsigned ACK_TMO   = 15
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [31:0]         Pc,
    input  logic                Ov,
    input  logic                Sys,
    input  logic                Ri,
    input  logic                Eret,
    input  logic                Mtc0,
    input  logic [4:0]          Cp0_rd,
    input  logic [31:0]         Wdata,
    output logic [31:0]         Rdata,
    input  logic [NUM_IRQ-1:0]  Intr,
    output logic [NUM_IRQ-1:0]  Inta,
    output logic                Exc_take,
    output logic [31:0]         Exc_pc,
    output logic [31:0]         Sta,
    output logic [31:0]         Cau
);

    localparam int unsigned IW = idx_width(NUM_IRQ);
    localparam int unsigned CW = $clog2(ACK_TMO + 1);

    logic               ie, exl, ack_to;
    logic [NUM_IRQ-1:0] im, ip, inta_q;
    logic [4:0]         exc_code;
    logic [31:0]        epc;
    ack_state_t         state;
    logic [IW-1:0]      ack_line;
    logic [CW-1:0]      ack_cnt;

    logic               irq_valid, exc_hit, irq_take, take_any;
    logic [IW-1:0]      irq_idx;
    logic [4:0]         exc_sel;

    irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arb (
        .req   (ip & im),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    always_comb begin
        exc_hit  = Ri | Sys | Ov;
        exc_sel  = Ri ? EXC_RI : (Sys ? EXC_SYS : EXC_OV);
        irq_take = !exc_hit && !Eret && ie && !exl && irq_valid && (state == IDLE);
        take_any = exc_hit | irq_take;
        Exc_take = take_any | Eret;
        if (exc_hit)
            Exc_pc = VEC_EXC;
        else if (irq_take)
            Exc_pc = VEC_IRQ + (32'(irq_idx) << VEC_SHIFT);
        else
            Exc_pc = epc;
    end

    always_comb begin
        Sta                   = '0;
        Sta[ST_IE]            = ie;
        Sta[ST_EXL]           = exl;
        Sta[ST_IM +: NUM_IRQ] = im;
        Cau                          = '0;
        Cau[CA_EXC_LO +: 5]          = exc_code;
        Cau[CA_ACKTO]                = ack_to;
        Cau[CA_IP +: NUM_IRQ]        = ip;
        case (Cp0_rd)
            CP0_STATUS: Rdata = Sta;
            CP0_CAUSE:  Rdata = Cau;
            CP0_EPC:    Rdata = epc;
            default:    Rdata = '0;
        endcase
    end

    assign Inta = inta_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ie       <= 1'b0;
            exl      <= 1'b0;
            im       <= '0;
            ip       <= '0;
            exc_code <= EXC_INT;
            ack_to   <= 1'b0;
            epc      <= '0;
            state    <= IDLE;
            ack_line <= '0;
            ack_cnt  <= '0;
            inta_q   <= '0;
        end else begin
            ip <= Intr;
            if (take_any) begin
                if (!exl)
                    epc <= Pc;
                exl      <= 1'b1;
                exc_code <= irq_take ? EXC_INT : exc_sel;
            end else begin
                if (Mtc0) begin
                    case (Cp0_rd)
                        CP0_STATUS: begin
                            ie  <= Wdata[ST_IE];
                            exl <= Wdata[ST_EXL];
                            im  <= Wdata[ST_IM +: NUM_IRQ];
                        end
                        CP0_CAUSE: ack_to <= Wdata[CA_ACKTO];
                        CP0_EPC:   epc    <= Wdata;
                        default: ;
                    endcase
                end
                if (Eret)
                    exl <= 1'b0;
            end

            // A timeout in the same cycle as an mtc0 clear keeps AckTo set.
            case (state)
                IDLE: begin
                    if (irq_take) begin
                        state    <= ACK;
                        ack_line <= irq_idx;
                        ack_cnt  <= '0;
                        inta_q   <= NUM_IRQ'(1) << irq_idx;
                    end
                end
                ACK: begin
                    if (!Intr[ack_line]) begin
                        state  <= IDLE;
                        inta_q <= '0;
                    end else if (ack_cnt == CW'(ACK_TMO - 1)) begin
                        state  <= IDLE;
                        inta_q <= '0;
                        ack_to <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Parametrised coprocessor-0 exception/interrupt controller for the single-cycle MIPS core.
- Holds Status, Cause and EPC. Arbitrates NUM_IRQ interrupt lines against synchronous exceptions (overflow, syscall, reserved instruction).
- Drives the PC redirect and a four-phase acknowledge handshake per line. Serves mfc0/mtc0/eret.
- Sits beside the control unit. Redirect outputs feed the PC mux.

Parameters:
NUM_IRQ, 4, interrupt lines; 1..8
VEC_EXC, 32'h0000_001c, exception vector
VEC_IRQ, 32'h0000_0040, interrupt vector base
VEC_SHIFT, 3, vectored stride = 1<<VEC_SHIFT bytes per line
ACK_TMO, 15, max cycles Inta held waiting for Intr release

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset
Pc  in  32  PC of current instruction
Ov  in  1  ALU overflow on current instruction (add/sub/addi)
Sys  in  1  syscall decoded
Ri  in  1  reserved/unimplemented opcode decoded
Eret  in  1  eret decoded
Mtc0  in  1  mtc0 write strobe
Cp0_rd  in  5  CP0 register select (12 Status, 13 Cause, 14 EPC)
Wdata  in  32  mtc0 data
Rdata  out  32  mfc0 data, combinational on Cp0_rd, 0 for unmapped
Intr  in  NUM_IRQ  level interrupt requests
Inta  out  NUM_IRQ  acknowledge, at most one bit high
Exc_take  out  1  redirect PC to Exc_pc this cycle; suppress Wreg/Wmem
Exc_pc  out  32  redirect target (vector or EPC on eret)
Sta  out  32  Status register
Cau  out  32  Cause register

Behaviour:
- Clocking/reset (already decided): one clock Clk; reset Rst is synchronous and active-high.
- Reset: Status=0, Cause=0, EPC=0, Inta=0, FSM=IDLE.
- Status fields: [0] IE, [1] EXL, [8+NUM_IRQ-1:8] IM. Other bits read 0; writes to them ignored.
- Cause fields: [6:2] ExcCode, [7] AckTo (sticky), [8+NUM_IRQ-1:8] IP. Other bits 0.
- IP tracking: IP[i] <= Intr[i] every cycle (registered, 1-cycle latency). Software cannot write IP.
- ExcCode values: Int=0, Sys=8, RI=10, Ov=12. Package these as constants.
- Exception priority within a cycle: Ri > Sys > Ov.
- Exceptions are taken regardless of IE.
- Interrupts are taken only when IE=1, EXL=0 and |(IP & IM).
- Among interrupt lines, the lowest index wins.
- A pending exception always beats an interrupt.
- On take, combinationally in the same cycle:
  - Exc_take=1.
  - Exc_pc = VEC_EXC for exceptions.
  - Exc_pc = VEC_IRQ + (i << VEC_SHIFT) for interrupt line i.
- On the take clock edge:
  - EPC <= Pc, but only if EXL was 0. A nested exception with EXL=1 keeps EPC and still redirects.
  - EXL <= 1.
  - ExcCode <= code.
- Eret (and no exception): Exc_take=1, Exc_pc=EPC. EXL <= 0 at the edge.
  - Interrupts are not evaluated in the eret cycle. Earliest take is the next cycle.
- Mtc0: write lands at the edge and is visible to take logic the next cycle.
  - Dropped if an exception or interrupt is taken in the same cycle.
  - Mtc0 to Cause writes only AckTo (write 0 clears it).
- Mfc0 on Status/Cause reflects the pre-edge value. No bypass of a same-cycle mtc0.
- Acknowledge FSM:
  - IDLE: on interrupt take of line i, latch i, clear counter, go to ACK.
  - ACK: Inta[i]=1; counter increments each cycle.
    - Intr[i]=0 → Inta drops next edge, go to IDLE.
    - Counter reaches ACK_TMO → Inta drops, AckTo <= 1, go to IDLE.
  - No new interrupt take while in ACK. Exceptions are still taken.
- Reset mid-ACK: Inta drops at that edge; FSM returns to IDLE.
- Widths: PC arithmetic is 32-bit wraparound. Vector offset is zero-extended.

Decomposition:
- Package cp0_pkg holds:
  - register select numbers 12/13/14
  - Status/Cause bit positions
  - ExcCode constants
  - FSM state enum {IDLE, ACK}
- Sub-module irq_arbiter: combinational lowest-index priority encoder over IP & IM.
  - Outputs valid + index, width $clog2(NUM_IRQ).
  - Handles NUM_IRQ=1 by forcing index width 1.

Test Plan:
- Reset then mfc0 12/13/14 → all read 0; Inta=0; Exc_take=0.
- Status=0x0301 (IE, IM0, IM1); Intr=4'b0011 for 2 cycles; Pc=0x100 → take line 0, Exc_pc=0x40, EPC=0x100, EXL=1, Inta=4'b0001 until Intr[0] falls.
- Ov=1 and Intr[0]=1 same cycle, Pc=0x200 → exception wins: Exc_pc=0x1c, ExcCode=12, EPC=0x200, Inta stays 0.
- In handler (EXL=1) Sys=1, Pc=0x50 → Exc_pc=0x1c, ExcCode=8, EPC unchanged 0x200; then Eret → Exc_pc=0x200, EXL=0 next cycle.
- Intr[2] held high after take → Inta[2] high 15 cycles, then drops, Cause[7]=1; mtc0 Cause=0 clears it.
- Rst asserted while in ACK → Inta=0, Status/Cause/EPC=0 after the edge.
